// File: rtl/lane_serializer.sv
// Per-lane parallel-to-serial stage: one-entry holding register feeding an LSB-first shifter,
// with gap-free back-to-back symbols and optional idle-symbol fill on underrun.
module lane_serializer #(
  parameter int                      SYMBOL_WIDTH = 10,
  parameter bit                      IDLE_FILL    = 1'b0,
  parameter logic [SYMBOL_WIDTH-1:0] IDLE_SYMBOL  = 10'h17C,
  parameter int                      CNT_WIDTH    = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    enable_i,
  input  logic [SYMBOL_WIDTH-1:0] symbol_i,
  input  logic                    symbol_valid_i,
  output logic                    symbol_ready_o,
  output logic                    lane_bit_o,
  output logic                    lane_bit_valid_o,
  output logic                    underrun_o,
  output logic [CNT_WIDTH-1:0]    symbol_count_o
);

  localparam int            BW   = $clog2(SYMBOL_WIDTH);
  localparam logic [BW-1:0] LAST = BW'(SYMBOL_WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                  state_q, state_d;
  logic [SYMBOL_WIDTH-1:0] hold_q, hold_d;
  logic                    hold_valid_q, hold_valid_d;
  logic [SYMBOL_WIDTH-1:0] shift_q, shift_d;
  logic [BW-1:0]           bit_cnt_q, bit_cnt_d;
  logic [CNT_WIDTH-1:0]    count_q, count_d;
  logic                    underrun_q, underrun_d;
  logic                    accept, load_data;

  assign symbol_ready_o   = enable_i & ~hold_valid_q;
  assign accept           = symbol_valid_i & symbol_ready_o;
  assign lane_bit_o       = shift_q[0];
  assign lane_bit_valid_o = (state_q == SHIFT);
  assign underrun_o       = underrun_q;
  assign symbol_count_o   = count_q;

  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    count_d      = count_q;
    underrun_d   = 1'b0;
    load_data    = 1'b0;

    // accept and load are exclusive: ready is low whenever the holding register is full
    if (accept) begin
      hold_d       = symbol_i;
      hold_valid_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (hold_valid_q && enable_i) load_data = 1'b1;
      end
      SHIFT: begin
        shift_d   = shift_q >> 1;
        bit_cnt_d = bit_cnt_q + 1'b1;
        if (bit_cnt_q == LAST) begin
          bit_cnt_d = '0;
          if (hold_valid_q && enable_i) begin
            load_data = 1'b1;
          end else if (IDLE_FILL && enable_i) begin
            shift_d    = IDLE_SYMBOL;
            underrun_d = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (load_data) begin
      shift_d      = hold_q;
      hold_valid_d = 1'b0;
      bit_cnt_d    = '0;
      count_d      = count_q + 1'b1;
      state_d      = SHIFT;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      count_q      <= '0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      count_q      <= count_d;
      underrun_q   <= underrun_d;
    end
  end

endmodule

// File: tb/tb_lane_serializer.sv
// Bench for lane_serializer: lane A (no fill, 4-bit counter) and lane B (idle fill), checked against
// a symbol-level model of the expected serial stream.
module tb_lane_serializer;

  logic       clk = 1'b0;
  logic       rst;
  logic       en_a, sv_a, rdy_a, bit_a, vld_a, und_a;
  logic       en_b, sv_b, rdy_b, bit_b, vld_b, und_b;
  logic [9:0] sym_a, sym_b;
  logic [3:0] cnt_a;
  logic [15:0] cnt_b;

  always #5 clk = ~clk;

  lane_serializer #(.SYMBOL_WIDTH(10), .IDLE_FILL(1'b0), .IDLE_SYMBOL(10'h17C), .CNT_WIDTH(4)) u_a (
    .clk_i(clk), .rst_i(rst), .enable_i(en_a), .symbol_i(sym_a), .symbol_valid_i(sv_a),
    .symbol_ready_o(rdy_a), .lane_bit_o(bit_a), .lane_bit_valid_o(vld_a), .underrun_o(und_a),
    .symbol_count_o(cnt_a));

  lane_serializer #(.SYMBOL_WIDTH(10), .IDLE_FILL(1'b1), .IDLE_SYMBOL(10'h17C), .CNT_WIDTH(16)) u_b (
    .clk_i(clk), .rst_i(rst), .enable_i(en_b), .symbol_i(sym_b), .symbol_valid_i(sv_b),
    .symbol_ready_o(rdy_b), .lane_bit_o(bit_b), .lane_bit_valid_o(vld_b), .underrun_o(und_b),
    .symbol_count_o(cnt_b));

  int n_cmp = 0, n_bad = 0;
  logic rx_a[$], rx_b[$];
  int   bursts_a[$], bursts_b[$];
  int   run_a = 0, run_b = 0, un_a = 0, un_b = 0;
  logic [9:0] exp_a[$];
  int   cnt_a_exp = 0;

  // Stream monitor: collects every valid serial bit and the length of each contiguous valid run
  always @(negedge clk) begin
    if (vld_a) begin rx_a.push_back(bit_a); run_a++; end
    else if (run_a > 0) begin bursts_a.push_back(run_a); run_a = 0; end
    if (vld_b) begin rx_b.push_back(bit_b); run_b++; end
    else if (run_b > 0) begin bursts_b.push_back(run_b); run_b = 0; end
    if (und_a) un_a++;
    if (und_b) un_b++;
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_a(input logic [9:0] s);
    int t = 0;
    sv_a = 1'b1; sym_a = s;
    @(negedge clk);
    while (!rdy_a && t < 300) begin @(negedge clk); t++; end
    chk("send_a_ready_wait", longint'(t < 300), 1);
    @(posedge clk); #1;
    sv_a = 1'b0;
  endtask

  task automatic send_b(input logic [9:0] s);
    int t = 0;
    sv_b = 1'b1; sym_b = s;
    @(negedge clk);
    while (!rdy_b && t < 300) begin @(negedge clk); t++; end
    chk("send_b_ready_wait", longint'(t < 300), 1);
    @(posedge clk); #1;
    sv_b = 1'b0;
  endtask

  task automatic wait_idle_a();
    int t = 0;
    while (!(rdy_a && !vld_a) && t < 500) begin tick(); t++; end
    chk("idle_a_wait", longint'(t < 500), 1);
    tick();
  endtask

  // Rebuild 10-bit words LSB-first from the captured stream and compare with the sent symbols
  task automatic check_words_a(input string tag);
    logic [9:0] w;
    chk({tag, "_len"}, rx_a.size(), exp_a.size() * 10);
    while (exp_a.size() > 0 && rx_a.size() >= 10) begin
      for (int k = 0; k < 10; k++) w[k] = rx_a.pop_front();
      chk({tag, "_word"}, w, exp_a.pop_front());
    end
    exp_a.delete(); rx_a.delete(); bursts_a.delete();
  endtask

  initial begin
    logic [9:0] s, s2, d, w;
    logic [9:0] t2_syms[4];
    int t, nw, bad_mid;
    t2_syms = '{10'h3F0, 10'h17C, 10'h2AA, 10'h155};

    rst = 1'b1; en_a = 1'b0; en_b = 1'b0; sv_a = 1'b0; sv_b = 1'b0; sym_a = '0; sym_b = '0;
    repeat (3) tick();
    chk("rst_valid_a", vld_a, 0);
    chk("rst_bit_a", bit_a, 0);
    chk("rst_count_a", cnt_a, 0);
    chk("rst_ready_a", rdy_a, 0);
    chk("rst_underrun_b", und_b, 0);
    chk("rst_valid_b", vld_b, 0);
    rst = 1'b0;
    tick();
    en_a = 1'b1;
    tick();

    // single symbol, exact cycle timing
    s = 10'h3F0;
    send_a(s);
    chk("t1_ready_held", rdy_a, 0);
    chk("t1_valid_not_yet", vld_a, 0);
    tick();
    chk("t1_first_bit", {vld_a, bit_a}, {1'b1, s[0]});
    chk("t1_ready_back", rdy_a, 1);
    chk("t1_count", cnt_a, 1);
    for (int k = 1; k < 10; k++) begin
      tick();
      chk("t1_bit", {vld_a, bit_a}, {1'b1, s[k]});
    end
    tick();
    chk("t1_valid_drop", vld_a, 0);
    tick();
    exp_a.push_back(s); cnt_a_exp = 1;
    chk("t1_bursts", (bursts_a.size() == 1) ? bursts_a[0] : -1, 10);
    check_words_a("t1");

    // four symbols streamed back-to-back
    for (int i = 0; i < 4; i++) begin
      send_a(t2_syms[i]);
      exp_a.push_back(t2_syms[i]); cnt_a_exp++;
      if (i == 1) chk("t2_ready_low_while_held", rdy_a, 0);
    end
    wait_idle_a();
    chk("t2_single_burst", (bursts_a.size() == 1) ? bursts_a[0] : -1, 40);
    check_words_a("t2");
    chk("t2_count", cnt_a, cnt_a_exp % 16);

    // enable dropped mid-symbol with a second symbol held
    s = 10'($urandom); s2 = 10'($urandom);
    send_a(s);
    send_a(s2);
    chk("t4_bit1", {vld_a, bit_a}, {1'b1, s[1]});
    repeat (3) tick();
    en_a = 1'b0;
    chk("t4_bit4", {vld_a, bit_a}, {1'b1, s[4]});
    repeat (5) tick();
    chk("t4_bit9", {vld_a, bit_a}, {1'b1, s[9]});
    tick();
    chk("t4_valid_drop", vld_a, 0);
    chk("t4_ready_disabled", rdy_a, 0);
    repeat (4) tick();
    chk("t4_stays_idle", vld_a, 0);
    en_a = 1'b1;
    tick();
    chk("t4_resume_bit0", {vld_a, bit_a}, {1'b1, s2[0]});
    exp_a.push_back(s); exp_a.push_back(s2); cnt_a_exp += 2;
    wait_idle_a();
    chk("t4_two_bursts", bursts_a.size(), 2);
    check_words_a("t4");
    chk("t4_count", cnt_a, cnt_a_exp % 16);

    // asynchronous reset at bit 6
    s = 10'($urandom);
    send_a(s);
    repeat (7) tick();
    chk("t5_bit6", {vld_a, bit_a}, {1'b1, s[6]});
    rst = 1'b1;
    #1;
    chk("t5_async_valid", vld_a, 0);
    chk("t5_async_bit", bit_a, 0);
    chk("t5_async_count", cnt_a, 0);
    repeat (2) tick();
    rst = 1'b0;
    repeat (2) tick();
    rx_a.delete(); bursts_a.delete(); exp_a.delete(); cnt_a_exp = 0;
    s = 10'($urandom);
    send_a(s);
    exp_a.push_back(s); cnt_a_exp++;
    wait_idle_a();
    check_words_a("t5");
    chk("t5_count", cnt_a, cnt_a_exp % 16);

    // random symbols with random gaps, driving the 4-bit counter through its wrap
    for (int i = 0; i < 16; i++) begin
      s = 10'($urandom);
      send_a(s);
      exp_a.push_back(s); cnt_a_exp++;
      if (i == 13 || i == 14 || i == 15) begin
        wait_idle_a();
        chk("t6_count_wrap", cnt_a, cnt_a_exp % 16);
      end else begin
        repeat ($urandom_range(0, 12)) tick();
      end
    end
    wait_idle_a();
    check_words_a("t6");
    chk("a_no_underrun", un_a, 0);

    // idle fill on lane B
    en_b = 1'b1;
    tick();
    rx_b.delete(); bursts_b.delete(); un_b = 0;
    send_b(10'h3F0);
    repeat (35) tick();
    chk("t3_count_during_fill", cnt_b, 1);
    chk("t3_underrun_seen", longint'(un_b >= 1), 1);
    d = 10'($urandom);
    send_b(d);
    t = 0;
    while (cnt_b != 16'd2 && t < 50) begin tick(); t++; end
    chk("t3_data_loaded", cnt_b, 2);
    en_b = 1'b0;
    t = 0;
    while (vld_b && t < 50) begin tick(); t++; end
    chk("t3_lane_stops", vld_b, 0);
    tick();
    chk("t3_single_burst", bursts_b.size(), 1);
    chk("t3_len_mult", rx_b.size() % 10, 0);
    nw = rx_b.size() / 10;
    chk("t3_enough_words", longint'(nw >= 3), 1);
    if (nw >= 2) begin
      for (int k = 0; k < 10; k++) w[k] = rx_b.pop_front();
      chk("t3_first_word", w, 10'h3F0);
      bad_mid = 0;
      for (int i = 1; i < nw - 1; i++) begin
        for (int k = 0; k < 10; k++) w[k] = rx_b.pop_front();
        if (w !== 10'h17C) bad_mid++;
      end
      chk("t3_fill_words", bad_mid, 0);
      for (int k = 0; k < 10; k++) w[k] = rx_b.pop_front();
      chk("t3_last_word", w, d);
      chk("t3_underrun_per_fill", un_b, nw - 2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
